// File: rtl/ctprs_pool_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// ctprs_pool_scheduler_pkg
//   Shared constants and helpers for the CTPRS pool scheduler.
//   - TRUE / FALSE single-bit constants.
//   - FSM state encodings (IDLE / RUN / DRAIN) as plain logic constants so
//     legacy code and checkers can compare against them directly.
//   - log2()    : ceiling log2 with a floor of 1, used for pointer widths.
//   - mod_inc() : modulo-N increment used by the allocate/retire pointers.
// -----------------------------------------------------------------------------
package ctprs_pool_scheduler_pkg;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam int unsigned ST_W = 2;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   // Ceiling log2, never below 1 so a single-entry pool still gets a 1-bit
   // pointer.
   function automatic int unsigned log2(input int unsigned n);
      int unsigned r;
      r = 1;
      for (int unsigned i = 1; i < 31; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Next index in a ring of n entries: n-1 wraps back to 0.
   function automatic int unsigned mod_inc(input int unsigned idx,
                                           input int unsigned n);
      return ((idx + 1) >= n) ? 32'd0 : (idx + 1);
   endfunction

endpackage

// File: rtl/ctprs_pool_scheduler.sv
// -----------------------------------------------------------------------------
// ctprs_pool_scheduler
//   Hands sensor pixels (row, col, initial) to a pool of N_CTPRS camera-trace
//   projection row summers in round-robin order, and retires their sums in
//   exactly the order the pixels were allocated, producing one ordered result
//   stream per frame.
//
// Ports
//   CLK, RESET           clock, synchronous active-high reset
//   frame_start_i        pulse: IDLE -> RUN
//   frame_end_i          pulse: RUN -> DRAIN (wins over a same-cycle pixel)
//   px_valid_i/px_ready_o, px_row_i/px_col_i/px_initial_i
//                        pixel request channel
//   init_o               one-hot init pulse to the allocated summer
//   config_row_o/config_col_o/config_initial_o
//                        broadcast pixel config, registered with init_o
//   available_i          per-summer FREE flag
//   done_i               per-summer "result ready" flag
//   result_bus_i         summer[i] result at [i*FP_SIZE +: FP_SIZE]
//   sum_ack_o            one-hot retire pulse to the retired summer
//   out_valid_o/out_ready_i, out_row_o/out_col_o/out_result_o
//                        ordered result channel
//   frame_done_o         1-cycle pulse when the drain completes
//   busy_cnt_o           summers allocated and not yet retired
//   state_o              current FSM state (debug)
//
// Handshake rule for both channels: a transfer happens on a rising CLK edge
// where valid and ready are both high; a producer holding valid keeps its
// data stable until that edge, and ready may depend combinationally on the
// current cycle's inputs.
// -----------------------------------------------------------------------------
module ctprs_pool_scheduler
   import ctprs_pool_scheduler_pkg::*;
#(
   parameter int unsigned N_CTPRS      = 6,
   parameter int unsigned FP_SIZE      = 32,
   parameter int unsigned CAM_ROW_SIZE = 12,
   parameter int unsigned CAM_COL_SIZE = 12
) (
   input  logic                        CLK,
   input  logic                        RESET,
   input  logic                        frame_start_i,
   input  logic                        frame_end_i,
   input  logic                        px_valid_i,
   output logic                        px_ready_o,
   input  logic [CAM_ROW_SIZE-1:0]     px_row_i,
   input  logic [CAM_COL_SIZE-1:0]     px_col_i,
   input  logic [FP_SIZE-1:0]          px_initial_i,
   output logic [N_CTPRS-1:0]          init_o,
   output logic [CAM_ROW_SIZE-1:0]     config_row_o,
   output logic [CAM_COL_SIZE-1:0]     config_col_o,
   output logic [FP_SIZE-1:0]          config_initial_o,
   input  logic [N_CTPRS-1:0]          available_i,
   input  logic [N_CTPRS-1:0]          done_i,
   input  logic [N_CTPRS*FP_SIZE-1:0]  result_bus_i,
   output logic [N_CTPRS-1:0]          sum_ack_o,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [CAM_ROW_SIZE-1:0]     out_row_o,
   output logic [CAM_COL_SIZE-1:0]     out_col_o,
   output logic [FP_SIZE-1:0]          out_result_o,
   output logic                        frame_done_o,
   output logic [log2(N_CTPRS):0]      busy_cnt_o,
   output logic [ST_W-1:0]             state_o
);

   localparam int unsigned PTR_W = log2(N_CTPRS);
   localparam int unsigned CNT_W = PTR_W + 1;

   // ---------------------------------------------------------------- state
   logic [ST_W-1:0]          state_q,       state_d;
   logic [PTR_W-1:0]         alloc_ptr_q,   alloc_ptr_d;
   logic [PTR_W-1:0]         retire_ptr_q,  retire_ptr_d;
   logic [N_CTPRS-1:0]       busy_q,        busy_d;
   logic [CNT_W-1:0]         busy_cnt_q,    busy_cnt_d;

   // Per-slot tag RAM: the pixel each summer is working on.
   logic [CAM_ROW_SIZE-1:0]  tag_row_q [N_CTPRS];
   logic [CAM_COL_SIZE-1:0]  tag_col_q [N_CTPRS];

   logic [N_CTPRS-1:0]       init_q,        init_d;
   logic [CAM_ROW_SIZE-1:0]  cfg_row_q,     cfg_row_d;
   logic [CAM_COL_SIZE-1:0]  cfg_col_q,     cfg_col_d;
   logic [FP_SIZE-1:0]       cfg_init_q,    cfg_init_d;

   logic [N_CTPRS-1:0]       sum_ack_q,     sum_ack_d;
   logic                     out_valid_q,   out_valid_d;
   logic [CAM_ROW_SIZE-1:0]  out_row_q,     out_row_d;
   logic [CAM_COL_SIZE-1:0]  out_col_q,     out_col_d;
   logic [FP_SIZE-1:0]       out_result_q,  out_result_d;
   logic                     frame_done_q,  frame_done_d;

   // ------------------------------------------------------ result unpacking
   logic [FP_SIZE-1:0]       result_arr [N_CTPRS];

   always_comb begin
      for (int unsigned i = 0; i < N_CTPRS; i++) begin
         result_arr[i] = result_bus_i[i*FP_SIZE +: FP_SIZE];
      end
   end

   // ------------------------------------------------------- fire conditions
   logic alloc_fire;
   logic retire_fire;

   // frame_end_i gates ready so a pixel presented in the same cycle as the
   // end-of-frame pulse is refused rather than silently accepted.
   assign px_ready_o = (state_q == ST_RUN) && !frame_end_i &&
                       !busy_q[alloc_ptr_q] && available_i[alloc_ptr_q];

   assign alloc_fire = px_valid_i && px_ready_o;

   // Only the oldest outstanding slot may retire; a younger summer that is
   // already done simply keeps done asserted until its turn comes.
   assign retire_fire = busy_q[retire_ptr_q] && done_i[retire_ptr_q] &&
                        (!out_valid_q || out_ready_i);

   // -------------------------------------------------------------- FSM
   always_comb begin
      state_d      = state_q;
      frame_done_d = FALSE;
      case (state_q)
         ST_IDLE: begin
            if (frame_start_i) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (frame_end_i) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            // Drain finishes once every sum has left through the output
            // register, not merely once the summers are released.
            if ((busy_cnt_q == '0) && !out_valid_q) begin
               state_d      = ST_IDLE;
               frame_done_d = TRUE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ----------------------------------------------------------- allocation
   always_comb begin
      alloc_ptr_d = alloc_ptr_q;
      init_d      = '0;
      cfg_row_d   = cfg_row_q;
      cfg_col_d   = cfg_col_q;
      cfg_init_d  = cfg_init_q;
      if (alloc_fire) begin
         alloc_ptr_d         = PTR_W'(mod_inc(32'(alloc_ptr_q), N_CTPRS));
         init_d[alloc_ptr_q] = TRUE;
         cfg_row_d           = px_row_i;
         cfg_col_d           = px_col_i;
         cfg_init_d          = px_initial_i;
      end
   end

   // ----------------------------------------------------------- retirement
   always_comb begin
      retire_ptr_d  = retire_ptr_q;
      sum_ack_d     = '0;
      out_valid_d   = out_valid_q;
      out_row_d     = out_row_q;
      out_col_d     = out_col_q;
      out_result_d  = out_result_q;
      if (retire_fire) begin
         retire_ptr_d            = PTR_W'(mod_inc(32'(retire_ptr_q), N_CTPRS));
         sum_ack_d[retire_ptr_q] = TRUE;
         out_valid_d             = TRUE;
         out_row_d               = tag_row_q[retire_ptr_q];
         out_col_d               = tag_col_q[retire_ptr_q];
         out_result_d            = result_arr[retire_ptr_q];
      end else if (out_ready_i) begin
         out_valid_d = FALSE;
      end
   end

   // ------------------------------------------------- busy bits and count
   // Allocation and retirement never touch the same slot in one cycle: one
   // needs the busy bit clear, the other needs it set.
   always_comb begin
      busy_d = busy_q;
      if (alloc_fire)  busy_d[alloc_ptr_q]  = TRUE;
      if (retire_fire) busy_d[retire_ptr_q] = FALSE;

      busy_cnt_d = busy_cnt_q;
      case ({alloc_fire, retire_fire})
         2'b10:   busy_cnt_d = busy_cnt_q + CNT_W'(1);
         2'b01:   busy_cnt_d = busy_cnt_q - CNT_W'(1);
         default: busy_cnt_d = busy_cnt_q;
      endcase
   end

   // ------------------------------------------------------------ registers
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= ST_IDLE;
         alloc_ptr_q  <= '0;
         retire_ptr_q <= '0;
         busy_q       <= '0;
         busy_cnt_q   <= '0;
         init_q       <= '0;
         cfg_row_q    <= '0;
         cfg_col_q    <= '0;
         cfg_init_q   <= '0;
         sum_ack_q    <= '0;
         out_valid_q  <= FALSE;
         out_row_q    <= '0;
         out_col_q    <= '0;
         out_result_q <= '0;
         frame_done_q <= FALSE;
         for (int unsigned i = 0; i < N_CTPRS; i++) begin
            tag_row_q[i] <= '0;
            tag_col_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         alloc_ptr_q  <= alloc_ptr_d;
         retire_ptr_q <= retire_ptr_d;
         busy_q       <= busy_d;
         busy_cnt_q   <= busy_cnt_d;
         init_q       <= init_d;
         cfg_row_q    <= cfg_row_d;
         cfg_col_q    <= cfg_col_d;
         cfg_init_q   <= cfg_init_d;
         sum_ack_q    <= sum_ack_d;
         out_valid_q  <= out_valid_d;
         out_row_q    <= out_row_d;
         out_col_q    <= out_col_d;
         out_result_q <= out_result_d;
         frame_done_q <= frame_done_d;
         if (alloc_fire) begin
            tag_row_q[alloc_ptr_q] <= px_row_i;
            tag_col_q[alloc_ptr_q] <= px_col_i;
         end
      end
   end

   // -------------------------------------------------------------- outputs
   assign init_o           = init_q;
   assign config_row_o     = cfg_row_q;
   assign config_col_o     = cfg_col_q;
   assign config_initial_o = cfg_init_q;
   assign sum_ack_o        = sum_ack_q;
   assign out_valid_o      = out_valid_q;
   assign out_row_o        = out_row_q;
   assign out_col_o        = out_col_q;
   assign out_result_o     = out_result_q;
   assign frame_done_o     = frame_done_q;
   assign busy_cnt_o       = busy_cnt_q;
   assign state_o          = state_q;

endmodule

// File: tb/tb_ctprs_pool_scheduler.sv
// -----------------------------------------------------------------------------
// tb_ctprs_pool_scheduler
//   Bench for ctprs_pool_scheduler. Contains a behavioural summer pool (each
//   summer returns f(initial) after a latency, then goes FREE again a few
//   cycles after its retire pulse) and a reference model: pixels accepted are
//   queued in arrival order and must come out in that order, init pulses and
//   retire pulses must walk the slots round-robin, busy_cnt must equal
//   inits seen minus acks seen.
// -----------------------------------------------------------------------------
module tb_ctprs_pool_scheduler;
   import ctprs_pool_scheduler_pkg::*;

   localparam int N  = 6;
   localparam int FP = 32;
   localparam int RW = 12;
   localparam int CW = 12;
   localparam int SW = RW + CW + FP;
   localparam int BW = log2(N) + 1;

   // ------------------------------------------------------ clock / reset
   logic CLK = 1'b0;
   logic RESET;
   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // ------------------------------------------------------------ DUT I/O
   logic              frame_start_i, frame_end_i;
   logic              px_valid_i, px_ready_o;
   logic [RW-1:0]     px_row_i;
   logic [CW-1:0]     px_col_i;
   logic [FP-1:0]     px_initial_i;
   logic [N-1:0]      init_o;
   logic [RW-1:0]     config_row_o;
   logic [CW-1:0]     config_col_o;
   logic [FP-1:0]     config_initial_o;
   logic [N-1:0]      available_i, done_i;
   logic [N*FP-1:0]   result_bus_i;
   logic [N-1:0]      sum_ack_o;
   logic              out_valid_o, out_ready_i;
   logic [RW-1:0]     out_row_o;
   logic [CW-1:0]     out_col_o;
   logic [FP-1:0]     out_result_o;
   logic              frame_done_o;
   logic [BW-1:0]     busy_cnt_o;
   logic [1:0]        state_o;

   ctprs_pool_scheduler #(
      .N_CTPRS(N), .FP_SIZE(FP), .CAM_ROW_SIZE(RW), .CAM_COL_SIZE(CW)
   ) dut (
      .CLK(CLK), .RESET(RESET),
      .frame_start_i(frame_start_i), .frame_end_i(frame_end_i),
      .px_valid_i(px_valid_i), .px_ready_o(px_ready_o),
      .px_row_i(px_row_i), .px_col_i(px_col_i), .px_initial_i(px_initial_i),
      .init_o(init_o), .config_row_o(config_row_o), .config_col_o(config_col_o),
      .config_initial_o(config_initial_o),
      .available_i(available_i), .done_i(done_i), .result_bus_i(result_bus_i),
      .sum_ack_o(sum_ack_o),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_row_o(out_row_o), .out_col_o(out_col_o), .out_result_o(out_result_o),
      .frame_done_o(frame_done_o), .busy_cnt_o(busy_cnt_o), .state_o(state_o)
   );

   // ------------------------------------------------------------ counters
   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // The summers' arithmetic as seen by the bench.
   function automatic logic [FP-1:0] summer_fn(input logic [FP-1:0] x);
      return x * 32'd3 + 32'h0000_1357;
   endfunction

   // ------------------------------------------------ summer pool model
   bit            s_busy [N];
   bit            s_done [N];
   bit            s_hold [N];     // freeze a summer before it finishes
   int            s_cnt  [N];
   int            s_av   [N];     // cycles until FREE after a retire pulse
   int            next_lat [N];   // forced latency for next job (0 = random)
   logic [FP-1:0] s_res  [N];

   always_comb begin
      for (int i = 0; i < N; i++) begin
         available_i[i]            = !s_busy[i] && !s_done[i] && (s_av[i] == 0);
         done_i[i]                 = s_done[i];
         result_bus_i[i*FP +: FP]  = s_res[i];
      end
   end

   always @(negedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < N; i++) begin
            s_busy[i] = 1'b0; s_done[i] = 1'b0; s_cnt[i] = 0; s_av[i] = 0;
            s_res[i]  = '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (sum_ack_o[i]) begin
               chk("ack_on_done_summer", {63'd0, s_done[i]}, 64'd1);
               s_busy[i] = 1'b0;
               s_done[i] = 1'b0;
               s_av[i]   = $urandom_range(0, 3);
            end else if (init_o[i]) begin
               chk("init_on_free_summer", {63'd0, s_busy[i] | s_done[i]}, 64'd0);
               s_busy[i] = 1'b1;
               s_res[i]  = summer_fn(config_initial_o);
               s_cnt[i]  = (next_lat[i] > 0) ? next_lat[i] : $urandom_range(1, 6);
            end else if (s_busy[i] && !s_done[i] && !s_hold[i]) begin
               if (s_cnt[i] <= 1) s_done[i] = 1'b1;
               else s_cnt[i]--;
            end else if (s_av[i] > 0) begin
               s_av[i]--;
            end
         end
      end
   end

   // ------------------------------------------------------ random ready
   bit   rand_mode = 1'b0;
   logic main_ready = 1'b0;
   logic rnd_ready  = 1'b1;
   assign out_ready_i = rand_mode ? rnd_ready : main_ready;

   always @(posedge CLK) begin
      #1;
      rnd_ready = ($urandom_range(0, 3) != 0);
   end

   // ------------------------------------------------ scoreboard / monitor
   logic [SW-1:0] exp_q [$];
   int            alloc_slot, ret_slot, prev_slot, cnt_model;
   bit            prev_hs, prev_stall;
   logic [SW-1:0] prev_out;
   int            ack_cyc [N];
   int            out_cnt = 0;
   int            last_out_cyc = 0;
   int            fd_cyc = 0;
   int            fd_count = 0;

   always begin
      @(negedge CLK);
      #2;
      if (RESET) begin
         exp_q.delete();
         alloc_slot = 0; ret_slot = 0; prev_slot = 0; cnt_model = 0;
         prev_hs = 1'b0; prev_stall = 1'b0;
         fd_count = 0;
         for (int i = 0; i < N; i++) ack_cyc[i] = 0;
      end else begin
         chk("init_slot", {58'd0, init_o},
             prev_hs ? (64'd1 << prev_slot) : 64'd0);
         if (init_o != '0) cnt_model++;
         if (sum_ack_o != '0) begin
            chk("ack_order", {58'd0, sum_ack_o}, 64'd1 << ret_slot);
            ack_cyc[ret_slot] = cyc;
            ret_slot = (ret_slot + 1) % N;
            cnt_model--;
         end
         chk("busy_cnt", {60'd0, busy_cnt_o}, 64'(cnt_model));
         if (prev_stall)
            chk("out_stable", {8'd0, out_row_o, out_col_o, out_result_o},
                {8'd0, prev_out});
         if (out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) chk("out_extra", {63'd0, out_valid_o}, 64'd0);
            else chk("out_data", {8'd0, out_row_o, out_col_o, out_result_o},
                     {8'd0, exp_q.pop_front()});
            out_cnt++;
            last_out_cyc = cyc;
         end
         if (frame_done_o) begin
            fd_cyc = cyc;
            fd_count++;
         end
         prev_stall = out_valid_o && !out_ready_i;
         prev_out   = {out_row_o, out_col_o, out_result_o};
         prev_hs    = px_valid_i && px_ready_o;
         if (prev_hs) begin
            exp_q.push_back({px_row_i, px_col_i, summer_fn(px_initial_i)});
            prev_slot  = alloc_slot;
            alloc_slot = (alloc_slot + 1) % N;
         end
      end
   end

   // ------------------------------------------------------ driver tasks
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      px_valid_i = 1'b0; frame_start_i = 1'b0; frame_end_i = 1'b0;
      main_ready = 1'b1; rand_mode = 1'b0;
      for (int i = 0; i < N; i++) begin
         s_hold[i] = 1'b0; next_lat[i] = 0;
      end
      tick(2);
      RESET = 1'b0;
   endtask

   task automatic pulse_start();
      frame_start_i = 1'b1;
      tick(1);
      frame_start_i = 1'b0;
   endtask

   task automatic pulse_end();
      frame_end_i = 1'b1;
      tick(1);
      frame_end_i = 1'b0;
   endtask

   task automatic send_px(input string tag, input logic [RW-1:0] r,
                          input logic [CW-1:0] c, input logic [FP-1:0] v);
      bit ok;
      px_valid_i = 1'b1; px_row_i = r; px_col_i = c; px_initial_i = v;
      ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(negedge CLK);
         #3;
         if (px_ready_o) begin
            ok = 1'b1;
            break;
         end
      end
      chk(tag, {63'd0, ok}, 64'd1);
      @(posedge CLK);
      #1;
      px_valid_i = 1'b0;
   endtask

   task automatic wait_drained(input string tag);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge CLK);
         #3;
         if (busy_cnt_o == '0 && !out_valid_o && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      chk(tag, {63'd0, ok}, 64'd1);
   endtask

   task automatic wait_frame_done(input string tag);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 4000; k++) begin
         @(negedge CLK);
         #3;
         if (frame_done_o) begin
            ok = 1'b1;
            break;
         end
      end
      chk(tag, {63'd0, ok}, 64'd1);
   endtask

   // ----------------------------------------------------------- stimulus
   initial begin
      logic [RW-1:0] r0, r1;
      logic [CW-1:0] c0, c1;
      int            base;

      RESET = 1'b1;
      px_valid_i = 1'b0; frame_start_i = 1'b0; frame_end_i = 1'b0;
      px_row_i = '0; px_col_i = '0; px_initial_i = '0;
      tick(3);
      // Reset state
      chk("rst_state",    {62'd0, state_o}, {62'd0, ST_IDLE});
      chk("rst_init",     {58'd0, init_o}, 64'd0);
      chk("rst_ack",      {58'd0, sum_ack_o}, 64'd0);
      chk("rst_out_valid",{63'd0, out_valid_o}, 64'd0);
      chk("rst_frame_done",{63'd0, frame_done_o}, 64'd0);
      chk("rst_busy_cnt", {60'd0, busy_cnt_o}, 64'd0);
      chk("rst_config",   {8'd0, config_row_o, config_col_o, config_initial_o}, 64'd0);
      chk("rst_out_data", {8'd0, out_row_o, out_col_o, out_result_o}, 64'd0);
      RESET = 1'b0;
      main_ready = 1'b1;

      // 1: three pixels on row 5, summers finish in order.
      do_reset();
      pulse_start();
      chk("t1_state_run", {62'd0, state_o}, {62'd0, ST_RUN});
      base = out_cnt;
      for (int c = 0; c < 3; c++) begin
         next_lat[c] = 4 + c;
         send_px("t1_accept", 12'd5, CW'(c), $urandom);
      end
      wait_drained("t1_drain");
      chk("t1_out_count", 64'(out_cnt - base), 64'd3);
      chk("t1_busy_zero", {60'd0, busy_cnt_o}, 64'd0);

      // 2: slot 2 finishes ~20+ cycles before slots 0 and 1.
      do_reset();
      pulse_start();
      next_lat[0] = 30; next_lat[1] = 30; next_lat[2] = 4;
      for (int c = 0; c < 3; c++) send_px("t2_accept", 12'd7, CW'(c), $urandom);
      wait_drained("t2_drain");
      chk("t2_ack2_after_ack1", {63'd0, ack_cyc[2] > ack_cyc[1]}, 64'd1);

      // 3: pool full.
      do_reset();
      pulse_start();
      for (int i = 0; i < N; i++) s_hold[i] = 1'b1;
      for (int c = 0; c < N; c++) send_px("t3_accept", 12'd9, CW'(c), $urandom);
      chk("t3_busy_full", {60'd0, busy_cnt_o}, 64'(N));
      px_valid_i = 1'b1; px_row_i = 12'd9; px_col_i = 12'd6;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         #3;
         chk("t3_ready_low_full", {63'd0, px_ready_o}, 64'd0);
      end
      s_hold[0] = 1'b0;
      send_px("t3_accept7", 12'd9, 12'd6, $urandom);
      chk("t3_seventh_slot0", {58'd0, init_o}, 64'd1);
      for (int i = 0; i < N; i++) s_hold[i] = 1'b0;
      send_px("t3_accept8", 12'd9, 12'd7, $urandom);
      chk("t3_eighth_slot1", {58'd0, init_o}, 64'd2);
      wait_drained("t3_drain");

      // 4: backpressure with two results ready.
      do_reset();
      main_ready = 1'b0;
      pulse_start();
      r0 = 12'h0A1; c0 = 12'h011; r1 = 12'h0A2; c1 = 12'h022;
      next_lat[0] = 2; next_lat[1] = 2;
      send_px("t4_accept", r0, c0, $urandom);
      send_px("t4_accept", r1, c1, $urandom);
      tick(8);
      chk("t4_done1_high",     {63'd0, done_i[1]}, 64'd1);
      chk("t4_held_valid",     {63'd0, out_valid_o}, 64'd1);
      chk("t4_held_first",     {40'd0, out_row_o, out_col_o}, {40'd0, r0, c0});
      chk("t4_ack1_withheld",  64'(ack_cyc[1]), 64'd0);
      chk("t4_busy_one",       {60'd0, busy_cnt_o}, 64'd1);
      main_ready = 1'b1;
      tick(1);
      chk("t4_second_valid",   {63'd0, out_valid_o}, 64'd1);
      chk("t4_second_data",    {40'd0, out_row_o, out_col_o}, {40'd0, r1, c1});
      pulse_end();
      wait_frame_done("t4_frame_done");

      // 5: frame_end with two pixels in flight and a pixel offered alongside.
      do_reset();
      pulse_start();
      for (int i = 0; i < N; i++) s_hold[i] = 1'b1;
      send_px("t5_accept", 12'd3, 12'd0, $urandom);
      send_px("t5_accept", 12'd3, 12'd1, $urandom);
      frame_end_i = 1'b1;
      px_valid_i = 1'b1; px_row_i = 12'd3; px_col_i = 12'd2;
      #2;
      chk("t5_ready_on_end", {63'd0, px_ready_o}, 64'd0);
      tick(1);
      frame_end_i = 1'b0;
      chk("t5_state_drain", {62'd0, state_o}, {62'd0, ST_DRAIN});
      chk("t5_ready_drain", {63'd0, px_ready_o}, 64'd0);
      tick(3);
      px_valid_i = 1'b0;
      for (int i = 0; i < N; i++) s_hold[i] = 1'b0;
      wait_frame_done("t5_frame_done");
      chk("t5_queue_empty",  64'(exp_q.size()), 64'd0);
      chk("t5_fd_after_out", 64'(fd_cyc - last_out_cyc), 64'd2);
      tick(3);
      chk("t5_state_idle",   {62'd0, state_o}, {62'd0, ST_IDLE});
      chk("t5_fd_once",      64'(fd_count), 64'd1);

      // 6: reset with four in flight.
      do_reset();
      pulse_start();
      for (int i = 0; i < N; i++) s_hold[i] = 1'b1;
      for (int c = 0; c < 4; c++) send_px("t6_accept", 12'd4, CW'(c), $urandom);
      chk("t6_busy_four", {60'd0, busy_cnt_o}, 64'd4);
      RESET = 1'b1;
      tick(1);
      chk("t6_state",     {62'd0, state_o}, {62'd0, ST_IDLE});
      chk("t6_busy_cnt",  {60'd0, busy_cnt_o}, 64'd0);
      chk("t6_ctrl",      {50'd0, init_o, sum_ack_o, out_valid_o, frame_done_o}, 64'd0);
      chk("t6_config",    {8'd0, config_row_o, config_col_o, config_initial_o}, 64'd0);
      chk("t6_out_data",  {8'd0, out_row_o, out_col_o, out_result_o}, 64'd0);
      RESET = 1'b0;

      // Random frame: random pixels, gaps, latencies, FREE delays, ready.
      do_reset();
      pulse_start();
      rand_mode = 1'b1;
      base = out_cnt;
      for (int k = 0; k < 40; k++) begin
         send_px("rnd_accept", RW'($urandom_range(0, 4095)),
                 CW'($urandom_range(0, 4095)), $urandom);
         tick($urandom_range(0, 2));
      end
      pulse_end();
      wait_frame_done("rnd_frame_done");
      chk("rnd_out_count",   64'(out_cnt - base), 64'd40);
      chk("rnd_queue_empty", 64'(exp_q.size()), 64'd0);
      chk("rnd_busy_zero",   {60'd0, busy_cnt_o}, 64'd0);
      rand_mode = 1'b0;
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
